// File: rtl/fft_fixed_pkg.sv
// Shared types and sign-magnitude <-> two's-complement helpers for the FFT fixed-point datapath.
package fft_fixed_pkg;

    typedef logic [15:0] sm_q7_8_t;

    typedef enum logic [2:0] {IDLE, MUL_RR, MUL_II, MUL_RI, MUL_IR, OUT} tmc_state_t;

    localparam sm_q7_8_t SM_MAX = 16'h7FFF;

    typedef struct packed {
        logic     sat;
        sm_q7_8_t value;
    } sm_sat_t;

    // Negative zero maps to plain zero here, so it never reaches the adders.
    function automatic logic signed [16:0] sm_to_tc(input sm_q7_8_t x);
        logic signed [16:0] mag;
        mag = {2'b00, x[14:0]};
        return x[15] ? -mag : mag;
    endfunction

    function automatic sm_sat_t tc_to_sm_sat(input logic signed [16:0] x);
        sm_sat_t    r;
        logic [16:0] mag;
        mag = x[16] ? -x : x;
        r.sat = (mag > {1'b0, SM_MAX});
        if (r.sat)
            r.value = {x[16], SM_MAX[14:0]};
        else if (mag == 17'd0)
            r.value = 16'h0000;
        else
            r.value = {x[16], mag[14:0]};
        return r;
    endfunction

endpackage

// File: rtl/fixed_point_math.sv
// Combinational 16-bit sign-magnitude Q7.8 multiplier; magnitude truncated and clipped to 0x7FFF.
module fixed_point_math (
    input  logic [15:0] input1,
    input  logic [15:0] input2,
    output logic [15:0] product
);
    logic [29:0] mag_full;
    logic [21:0] mag_q;

    assign mag_full = {15'b0, input1[14:0]} * {15'b0, input2[14:0]};
    assign mag_q    = 22'(mag_full >> 8);
    assign product  = {input1[15] ^ input2[15], (|mag_q[21:15]) ? 15'h7FFF : mag_q[14:0]};

endmodule

// File: rtl/twiddle_mult_ctrl.sv
// Complex twiddle multiply: four real products through one shared multiplier, then saturating add/sub.
module twiddle_mult_ctrl
    import fft_fixed_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int CONJ   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_sat
);
    if (DATA_W != 16 || FRAC_W != 8) begin : g_bad_format
        $error("twiddle_mult_ctrl supports only 16-bit Q7.8 operands");
    end

    tmc_state_t state, next_state;
    sm_q7_8_t   op_a_re, op_a_im, op_w_re, op_w_im;
    sm_q7_8_t   p_rr, p_ri;
    sm_sat_t    acc_re;
    sm_q7_8_t   mul_in1, mul_in2, mul_out;
    logic signed [16:0] sum_re, sum_im;
    sm_sat_t    res_re, res_im;

    fixed_point_math u_mul (
        .input1  (mul_in1),
        .input2  (mul_in2),
        .product (mul_out)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        mul_in1    = '0;
        mul_in2    = '0;
        case (state)
            IDLE:    if (in_valid) next_state = MUL_RR;
            MUL_RR:  begin mul_in1 = op_a_re; mul_in2 = op_w_re; next_state = MUL_II; end
            MUL_II:  begin mul_in1 = op_a_im; mul_in2 = op_w_im; next_state = MUL_RI; end
            MUL_RI:  begin mul_in1 = op_a_re; mul_in2 = op_w_im; next_state = MUL_IR; end
            MUL_IR:  begin mul_in1 = op_a_im; mul_in2 = op_w_re; next_state = OUT;    end
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // mul_out is p_ii in MUL_II and p_ir in MUL_IR.
    always_comb begin
        if (CONJ != 0) begin
            sum_re = sm_to_tc(p_rr) + sm_to_tc(mul_out);
            sum_im = sm_to_tc(mul_out) - sm_to_tc(p_ri);
        end else begin
            sum_re = sm_to_tc(p_rr) - sm_to_tc(mul_out);
            sum_im = sm_to_tc(p_ri) + sm_to_tc(mul_out);
        end
        res_re = tc_to_sm_sat(sum_re);
        res_im = tc_to_sm_sat(sum_im);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_re  <= '0;
            out_im  <= '0;
            out_sat <= 1'b0;
        end else begin
            state <= next_state;
            if (state == MUL_IR) begin
                out_re  <= acc_re.value;
                out_im  <= res_im.value;
                out_sat <= acc_re.sat | res_im.sat;
            end
        end
    end

    // NOTE: operand and partial-product registers are not reset; they are always written before use.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (in_valid) begin
                op_a_re <= a_re;
                op_a_im <= a_im;
                op_w_re <= w_re;
                op_w_im <= w_im;
            end
            MUL_RR:  p_rr   <= mul_out;
            MUL_II:  acc_re <= res_re;
            MUL_RI:  p_ri   <= mul_out;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_twiddle_mult_ctrl.sv
// Self-checking bench: CONJ=0 and CONJ=1 instances on shared stimulus, checked against an arithmetic model.
module tb_twiddle_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a_re = '0, a_im = '0, w_re = '0, w_im = '0;

    logic        in_ready0, out_valid0, out_sat0, in_ready1, out_valid1, out_sat1;
    logic [15:0] out_re0, out_im0, out_re1, out_im1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    twiddle_mult_ctrl #(.DATA_W(16), .FRAC_W(8), .CONJ(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_re(out_re0), .out_im(out_im0), .out_sat(out_sat0)
    );

    twiddle_mult_ctrl #(.DATA_W(16), .FRAC_W(8), .CONJ(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_re(out_re1), .out_im(out_im1), .out_sat(out_sat1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: plain integer arithmetic ----------------
    function automatic int mul_val(input logic [15:0] x, input logic [15:0] y);
        int m;
        m = (int'(x[14:0]) * int'(y[14:0])) >>> 8;
        if (m > 32767) m = 32767;
        return (x[15] ^ y[15]) ? -m : m;
    endfunction

    // Returns {sat, sign-magnitude result}; zero is always 0x0000.
    function automatic logic [16:0] clip(input int v);
        int   m;
        logic s;
        s = (v < 0);
        m = s ? -v : v;
        if (m > 32767) return {1'b1, s, 15'h7FFF};
        if (m == 0)    return 17'h0;
        return {1'b0, s, m[14:0]};
    endfunction

    int          cnt = 0;          // 0 idle, 1..4 busy, 5 result presented
    bit          model_live = 1'b0;
    bit          zero_since_rst = 1'b0;
    logic [16:0] pend_re [2], pend_im [2];
    logic [15:0] e_re [2], e_im [2];
    logic        e_sat [2];

    always @(posedge clk) begin
        int rr, ii, ri, ir;
        model_live = 1'b1;
        if (rst) begin
            cnt = 0;
            zero_since_rst = 1'b1;
            for (int k = 0; k < 2; k++) begin
                e_re[k] = '0; e_im[k] = '0; e_sat[k] = 1'b0;
            end
        end else if (cnt == 0) begin
            if (in_valid) begin
                rr = mul_val(a_re, w_re);
                ii = mul_val(a_im, w_im);
                ri = mul_val(a_re, w_im);
                ir = mul_val(a_im, w_re);
                pend_re[0] = clip(rr - ii);
                pend_im[0] = clip(ri + ir);
                pend_re[1] = clip(rr + ii);
                pend_im[1] = clip(ir - ri);
                cnt = 1;
            end
        end else if (cnt < 5) begin
            if (cnt == 4) begin
                for (int k = 0; k < 2; k++) begin
                    e_re[k]  = pend_re[k][15:0];
                    e_im[k]  = pend_im[k][15:0];
                    e_sat[k] = pend_re[k][16] | pend_im[k][16];
                end
                zero_since_rst = 1'b0;
            end
            cnt++;
        end else if (out_ready) begin
            cnt = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("in_ready0",  {31'b0, in_ready0},  {31'b0, cnt == 0});
            check("in_ready1",  {31'b0, in_ready1},  {31'b0, cnt == 0});
            check("out_valid0", {31'b0, out_valid0}, {31'b0, cnt == 5});
            check("out_valid1", {31'b0, out_valid1}, {31'b0, cnt == 5});
            if (cnt == 5 || zero_since_rst) begin
                check("out_re0",  {16'b0, out_re0},  {16'b0, e_re[0]});
                check("out_im0",  {16'b0, out_im0},  {16'b0, e_im[0]});
                check("out_sat0", {31'b0, out_sat0}, {31'b0, e_sat[0]});
                check("out_re1",  {16'b0, out_re1},  {16'b0, e_re[1]});
                check("out_im1",  {16'b0, out_im1},  {16'b0, e_im[1]});
                check("out_sat1", {31'b0, out_sat1}, {31'b0, e_sat[1]});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] cap_re0, cap_im0, cap_re1, cap_im1;
    logic        cap_sat0, cap_sat1;

    function automatic logic [15:0] rnd_operand();
        logic [15:0] m;
        m = 16'($urandom_range(0, 32767) >> $urandom_range(0, 8));
        if ($urandom_range(0, 15) == 0) m = 16'h0000;
        return {1'($urandom), m[14:0]};
    endfunction

    task automatic send(input logic [15:0] ar, ai, wr, wi, input int stall, input bit rnd);
        bit ok;
        @(posedge clk); #1;
        a_re = ar; a_im = ai; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready0) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready never high, expected within 20 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rnd) begin
                out_ready = 1'($urandom);
                in_valid  = 1'($urandom);
                a_re = rnd_operand(); a_im = rnd_operand();
                w_re = rnd_operand(); w_im = rnd_operand();
            end
            @(negedge clk);
            if (out_valid0) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL result_timeout: out_valid never high, expected within 20 cycles");
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            return;
        end
        cap_re0 = out_re0; cap_im0 = out_im0; cap_sat0 = out_sat0;
        cap_re1 = out_re1; cap_im1 = out_im1; cap_sat1 = out_sat1;
        if (!rnd) out_ready = 1'b0;
        if (!out_ready) begin
            repeat (rnd ? $urandom_range(0, 3) : stall) @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready0},  32'd1);
        check("rst_out_valid", {31'b0, out_valid0}, 32'd0);
        check("rst_out_re",    {16'b0, out_re0},    32'h0);

        // 1: (1 + 0j) * (0.5 + 0.5j)
        send(16'h0100, 16'h0000, 16'h0080, 16'h0080, 0, 1'b0);
        check("t1_re",  {16'b0, cap_re0}, 32'h0080);
        check("t1_im",  {16'b0, cap_im0}, 32'h0080);
        check("t1_sat", {31'b0, cap_sat0}, 32'd0);

        // 2: (3 + 3j) * (3 - 3j) = 18, imaginary part exactly zero
        send(16'h0300, 16'h0300, 16'h0300, 16'h8300, 0, 1'b0);
        check("t2_re",  {16'b0, cap_re0}, 32'h1200);
        check("t2_im",  {16'b0, cap_im0}, 32'h0000);
        check("t2_sat", {31'b0, cap_sat0}, 32'd0);

        // 3: imaginary part 200 clips to 0x7FFF
        send(16'h6400, 16'h6400, 16'h0100, 16'h0100, 0, 1'b0);
        check("t3_re",  {16'b0, cap_re0}, 32'h0000);
        check("t3_im",  {16'b0, cap_im0}, 32'h7FFF);
        check("t3_sat", {31'b0, cap_sat0}, 32'd1);

        // 4: downstream stall for 10 cycles
        send(16'h0100, 16'h0000, 16'h0080, 16'h0080, 10, 1'b0);
        check("t4_re", {16'b0, cap_re0}, 32'h0080);
        @(negedge clk);
        check("t4_idle_after_release", {31'b0, in_ready0}, 32'd1);

        // 5: reset while in MUL_RI drops the operation
        @(posedge clk); #1;
        a_re = 16'h0200; a_im = 16'h0100; w_re = 16'h0100; w_im = 16'h0100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_in_ready",  {31'b0, in_ready0},  32'd1);
        check("t5_out_valid", {31'b0, out_valid0}, 32'd0);
        check("t5_out_re",    {16'b0, out_re0},    32'h0);
        check("t5_out_im",    {16'b0, out_im0},    32'h0);
        send(16'h0100, 16'h0000, 16'h0080, 16'h0080, 0, 1'b0);
        check("t5_recover_re", {16'b0, cap_re0}, 32'h0080);

        // 6: conjugate multiply, (1 + 1j) * conj(1 + 1j) = 2
        send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 1'b0);
        check("t6_re",  {16'b0, cap_re1}, 32'h0200);
        check("t6_im",  {16'b0, cap_im1}, 32'h0000);
        check("t6_sat", {31'b0, cap_sat1}, 32'd0);

        // Random operands, random stalls and ignored in_valid/out_ready noise while busy
        for (int n = 0; n < 200; n++)
            send(rnd_operand(), rnd_operand(), rnd_operand(), rnd_operand(), 0, 1'b1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
